tdc_readout_ctrl: RTL and testbench

TDC_READOUT_CTRL -- requirements
Module: tdc_readout_ctrl

---
 rtl/tdc_pkg.sv | 24 ++
 rtl/tdc_result_fifo.sv | 51 +++++
 rtl/tdc_readout_ctrl.sv | 127 ++++++++++++
 tb/tb_tdc_readout_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types and widths for the TDC readout controller.
// A record is {timeout_flag, interval[8:0]}; a stamp is {coarse, fine}.
package tdc_pkg;

  localparam int unsigned COARSE_W = 4;
  localparam int unsigned FINE_W   = 5;
  localparam int unsigned STAMP_W  = 9;
  localparam int unsigned RES_W    = 10;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWaitStart,
    StWaitStop,
    StStore
  } tdc_state_e;

  typedef logic [STAMP_W-1:0] stamp_t;

  function automatic logic [RES_W-1:0] make_record(input logic timeout, input stamp_t interval);
    return {timeout, interval};
  endfunction

endpackage

// File: rtl/tdc_result_fifo.sv
// First-word-fall-through result buffer; DEPTH must be a power of 2 (>= 2).
// A push while full is accepted only when a pop happens in the same cycle.
module tdc_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= wdata;
        wr_q                <= wr_q + PtrOne;
      end
      if (do_pop) begin
        rd_q <= rd_q + PtrOne;
      end
    end
  end

endmodule

// File: rtl/tdc_readout_ctrl.sv
// Start/stop measurement sequencer for a coarse/fine TDC; results are queued
// as {timeout_flag, interval} in a small FWFT FIFO with a sticky overflow flag.
module tdc_readout_ctrl
  import tdc_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                start_hit,
  input  logic                stop_hit,
  input  logic [COARSE_W-1:0] out_count,
  input  logic [FINE_W-1:0]   bin_out,
  output logic                tdc_clear,
  output logic                busy,
  output logic [RES_W-1:0]    res_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                ovf
);

  localparam logic [COARSE_W-1:0] TimeoutCnt = COARSE_W'(TIMEOUT);

  tdc_state_e          state_q, state_d;
  stamp_t              stamp_s_q, stamp_s_d;
  stamp_t              stamp_now;
  logic [COARSE_W-1:0] timer_q, timer_d;
  logic [RES_W-1:0]    rec_q, rec_d;
  logic                enable_q;
  logic                ovf_q, ovf_d;
  logic                push, pop, full, empty;

  assign stamp_now = {out_count, bin_out};

  always_comb begin
    state_d   = state_q;
    stamp_s_d = stamp_s_q;
    timer_d   = timer_q;
    rec_d     = rec_q;
    push      = 1'b0;
    tdc_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StArm;
      end
      StArm: begin
        tdc_clear = 1'b1;
        state_d   = enable ? StWaitStart : StIdle;
      end
      StWaitStart: begin
        // A coincident stop is ignored: only the start is taken.
        if (!enable) begin
          state_d = StIdle;
        end else if (start_hit) begin
          stamp_s_d = stamp_now;
          timer_d   = '0;
          state_d   = StWaitStop;
        end
      end
      StWaitStop: begin
        timer_d = timer_q + 1'b1;
        // Stop is checked before timeout so a stop on the final cycle still counts.
        if (!enable) begin
          state_d = StIdle;
        end else if (stop_hit) begin
          rec_d   = make_record(1'b0, stamp_now - stamp_s_q);
          state_d = StStore;
        end else if (timer_d == TimeoutCnt) begin
          rec_d   = make_record(1'b1, '0);
          state_d = StStore;
        end
      end
      StStore: begin
        push    = 1'b1;
        state_d = enable ? StArm : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign pop = res_ready && !empty;

  always_comb begin
    ovf_d = ovf_q;
    if (enable && !enable_q) ovf_d = 1'b0;
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      stamp_s_q <= '0;
      timer_q   <= '0;
      rec_q     <= '0;
      enable_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      stamp_s_q <= stamp_s_d;
      timer_q   <= timer_d;
      rec_q     <= rec_d;
      enable_q  <= enable;
      ovf_q     <= ovf_d;
    end
  end

  tdc_result_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(RES_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata(rec_q),
    .rdata(res_data),
    .full (full),
    .empty(empty)
  );

  assign busy      = (state_q != StIdle);
  assign res_valid = !empty;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_tdc_readout_ctrl.sv
// Directed bench for tdc_readout_ctrl: a table of start/stop stamp pairs plus
// hand-written sequences for timeout, overflow, discard and reset corners.
module tb_tdc_readout_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       start_hit;
  logic       stop_hit;
  logic [3:0] out_count;
  logic [4:0] bin_out;
  logic       tdc_clear;
  logic       busy;
  logic [9:0] res_data;
  logic       res_valid;
  logic       res_ready;
  logic       ovf;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [3:0] sc;
    logic [4:0] sb;
    logic [3:0] ec;
    logic [4:0] eb;
    int         gap;
    logic [9:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  tdc_readout_ctrl #(
    .TIMEOUT   (12),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .start_hit(start_hit),
    .stop_hit (stop_hit),
    .out_count(out_count),
    .bin_out  (bin_out),
    .tdc_clear(tdc_clear),
    .busy     (busy),
    .res_data (res_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Entered in WAIT_START; returns with the DUT observed in ARM after the push.
  task automatic measure(input logic [3:0] sc, input logic [4:0] sb,
                         input logic [3:0] ec, input logic [4:0] eb, input int gap);
    start_hit = 1'b1; out_count = sc; bin_out = sb;
    tick();
    start_hit = 1'b0;
    repeat (gap - 1) tick();
    stop_hit = 1'b1; out_count = ec; bin_out = eb;
    tick();
    stop_hit = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int n_clr;
    int valid_seen;

    vecs[0] = '{4'd2,  5'd5,  4'd5,  5'd20, 3,  10'h06F};  // 3*32+15
    vecs[1] = '{4'd14, 5'd30, 4'd1,  5'd2,  3,  10'h044};  // wrap: 34-478 mod 512
    vecs[2] = '{4'd0,  5'd0,  4'd0,  5'd0,  1,  10'h000};
    vecs[3] = '{4'd0,  5'd1,  4'd15, 5'd31, 2,  10'h1FE};
    vecs[4] = '{4'd15, 5'd31, 4'd0,  5'd0,  1,  10'h001};
    vecs[5] = '{4'd3,  5'd10, 4'd3,  5'd4,  4,  10'h1FA};
    vecs[6] = '{4'd4,  5'd0,  4'd7,  5'd16, 12, 10'h070};  // stop on the timeout cycle

    rst = 1'b1; enable = 1'b0; start_hit = 1'b0; stop_hit = 1'b0;
    out_count = '0; bin_out = '0; res_ready = 1'b0;
    #3;
    check("reset_busy",  busy, 0);
    check("reset_clear", tdc_clear, 0);
    check("reset_valid", res_valid, 0);
    check("reset_data",  res_data, 0);
    check("reset_ovf",   ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 0);
    enable = 1'b1;
    tick();
    check("arm_clear", tdc_clear, 1);
    check("arm_busy",  busy, 1);
    tick();
    check("wait_start_clear", tdc_clear, 0);

    for (int i = 0; i < 7; i++) begin
      measure(vecs[i].sc, vecs[i].sb, vecs[i].ec, vecs[i].eb, vecs[i].gap);
      check("vec_valid", res_valid, 1);
      check("vec_data",  res_data, vecs[i].exp_data);
      check("vec_rearm", tdc_clear, 1);
      pop_one();
      check("vec_popped", res_valid, 0);
    end

    // Timeout: 12 WAIT_STOP cycles then a flagged record and re-arm.
    start_hit = 1'b1; out_count = 4'd1; bin_out = 5'd1;
    tick();
    start_hit = 1'b0;
    repeat (11) tick();
    check("to_still_waiting", busy & ~res_valid, 1);
    tick();
    check("to_in_store", res_valid, 0);
    tick();
    check("to_valid", res_valid, 1);
    check("to_data",  res_data, 10'h200);
    check("to_rearm", tdc_clear, 1);
    pop_one();

    // Coincident start+stop is a start; stop three cycles later, equal bins.
    start_hit = 1'b1; stop_hit = 1'b1; out_count = 4'd2; bin_out = 5'd7;
    tick();
    start_hit = 1'b0; stop_hit = 1'b0;
    check("same_no_store", res_valid, 0);
    tick();
    tick();
    stop_hit = 1'b1; out_count = 4'd5; bin_out = 5'd7;
    tick();
    stop_hit = 1'b0;
    tick();
    check("same_data", res_data, 10'h060);
    pop_one();

    // Lone stop in WAIT_START and a second start in WAIT_STOP are ignored.
    stop_hit = 1'b1; out_count = 4'd9; bin_out = 5'd9;
    tick();
    stop_hit = 1'b0;
    check("lone_stop_ignored", res_valid, 0);
    start_hit = 1'b1; out_count = 4'd1; bin_out = 5'd0;
    tick();
    start_hit = 1'b0;
    tick();
    start_hit = 1'b1; out_count = 4'd8; bin_out = 5'd8;
    tick();
    start_hit = 1'b0;
    stop_hit = 1'b1; out_count = 4'd2; bin_out = 5'd0;
    tick();
    stop_hit = 1'b0;
    tick();
    check("restart_ignored", res_data, 10'h020);
    pop_one();

    // Dropping enable mid-measurement discards it.
    start_hit = 1'b1; out_count = 4'd3; bin_out = 5'd3;
    tick();
    start_hit = 1'b0;
    enable = 1'b0;
    tick();
    check("discard_idle", busy, 0);
    tick();
    check("discard_no_push", res_valid, 0);
    enable = 1'b1;
    tick();
    tick();

    // Overflow: five results with no consumer.
    for (int k = 1; k <= 5; k++) begin
      measure(4'd0, 5'd0, 4'd0, 5'(k), 1);
      if (k == 4) check("ovf_before", ovf, 0);
      if (k == 5) check("ovf_after", ovf, 1);
      tick();
    end
    for (int k = 1; k <= 4; k++) begin
      check("drain_data", res_data, 32'(k));
      pop_one();
    end
    check("drain_empty", res_valid, 0);
    check("ovf_sticky", ovf, 1);
    enable = 1'b0;
    tick();
    check("ovf_held_idle", ovf, 1);
    enable = 1'b1;
    tick();
    check("ovf_cleared", ovf, 0);
    tick();

    // Full FIFO with a pop in the STORE cycle: push succeeds, no overflow.
    for (int k = 10; k <= 13; k++) begin
      measure(4'd0, 5'd0, 4'd0, 5'(k), 1);
      tick();
    end
    start_hit = 1'b1; out_count = 4'd0; bin_out = 5'd0;
    tick();
    start_hit = 1'b0;
    stop_hit = 1'b1; bin_out = 5'd14;
    tick();
    stop_hit = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("full_pushpop_ovf", ovf, 0);
    for (int k = 11; k <= 14; k++) begin
      check("full_pushpop_data", res_data, 32'(k));
      pop_one();
    end
    check("full_pushpop_empty", res_valid, 0);

    // Reset while in WAIT_STOP with a result queued.
    measure(4'd0, 5'd0, 4'd1, 5'd0, 1);
    tick();
    start_hit = 1'b1; out_count = 4'd6; bin_out = 5'd6;
    tick();
    start_hit = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy",  busy, 0);
    check("arst_valid", res_valid, 0);
    check("arst_data",  res_data, 0);
    check("arst_clear", tdc_clear, 0);
    check("arst_ovf",   ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    n_clr = 0;
    valid_seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (tdc_clear) n_clr++;
      if (res_valid) valid_seen++;
    end
    check("arst_one_clear", n_clr, 1);
    check("arst_fifo_empty", valid_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
